reg_access_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the register bus between NUM_REQ requesters (for example, test sequences and a backdoor-mirror agent).
- Each request is decoded to one of NUM_DUTS register-file instances of NUM_REGS registers each.
- Exactly one bus transaction is outstanding at a time.
- Every accepted request gets exactly one response: ack data, decode error or timeout error.

---
 rtl/reg_access_arbiter.sv | 270 +++++++++++++++++++++++++++
 tb/tb_reg_access_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_access_arbiter.sv
// -----------------------------------------------------------------------------
// reg_access_arbiter
//
// Shares one register bus between NUM_REQ requesters. Requests are granted in
// rotating-priority order, decoded to one of NUM_DUTS register-file instances,
// and run one at a time. Each accepted request receives exactly one response:
// ack data, decode error or timeout error.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset_n    : asynchronous active-low reset
//   req_valid  : per-requester request valid
//   req_write  : per-requester direction (1 = write)
//   req_addr   : packed request addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata  : packed write data, requester i at [i*DATA_W +: DATA_W]
//   req_ready  : one-hot accept strobe (combinational, only in IDLE)
//   rsp_valid  : one-hot single-cycle response strobe to the owner
//   rsp_rdata  : read data (0 for writes and errors)
//   rsp_err    : decode or timeout error, qualified by rsp_valid
//   bus_sel    : one-hot instance select, high for the whole access
//   bus_write  : bus direction
//   bus_addr   : register offset
//   bus_wdata  : bus write data
//   bus_rdata  : packed per-instance read data
//   bus_ack    : per-instance completion
// -----------------------------------------------------------------------------
module reg_access_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int NUM_DUTS = 1,
    parameter int NUM_REGS = 10,
    parameter int DATA_W   = 32,
    parameter int REG_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    parameter int ADDR_W   = 8,
    parameter int TIMEOUT  = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    output logic [NUM_DUTS-1:0]          bus_sel,
    output logic                         bus_write,
    output logic [REG_W-1:0]             bus_addr,
    output logic [DATA_W-1:0]            bus_wdata,
    input  logic [NUM_DUTS*DATA_W-1:0]   bus_rdata,
    input  logic [NUM_DUTS-1:0]          bus_ack
);

    localparam int OWN_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DSEL_W = (NUM_DUTS > 1) ? $clog2(NUM_DUTS) : 1;
    localparam int DUT_FW = ADDR_W - REG_W;
    localparam int CNT_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic [OWN_W-1:0]      last_grant_r;
    logic [OWN_W-1:0]      owner_r;
    logic                  write_r;
    logic [DSEL_W-1:0]     dut_r;
    logic [CNT_W-1:0]      cnt_r;

    logic [NUM_DUTS-1:0]   bus_sel_r;
    logic                  bus_write_r;
    logic [REG_W-1:0]      bus_addr_r;
    logic [DATA_W-1:0]     bus_wdata_r;
    logic [NUM_REQ-1:0]    rsp_valid_r;
    logic [DATA_W-1:0]     rsp_rdata_r;
    logic                  rsp_err_r;

    logic                  hi_found_s;
    logic                  lo_found_s;
    logic [OWN_W-1:0]      hi_idx_s;
    logic [OWN_W-1:0]      lo_idx_s;
    logic [OWN_W-1:0]      win_idx_s;
    logic [NUM_REQ-1:0]    grant_oh_s;
    logic [NUM_REQ-1:0]    owner_oh_s;
    logic                  win_write_s;
    logic [ADDR_W-1:0]     win_addr_s;
    logic [DATA_W-1:0]     win_wdata_s;
    logic [REG_W-1:0]      reg_off_s;
    logic [DUT_FW-1:0]     dut_field_s;
    logic                  dec_err_s;
    logic [NUM_DUTS-1:0]   dut_oh_s;
    logic                  ack_sel_s;
    logic [DATA_W-1:0]     rdata_sel_s;
    logic                  timeout_hit_s;

    // Rotating priority: lowest valid index above last_grant wins, otherwise the
    // lowest valid index overall (the wrap-around case). Scanning downwards lets
    // the last hit be the lowest index.
    always_comb begin
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_idx_s   = '0;
        lo_idx_s   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            hi_found_s = (req_valid[i] && (OWN_W'(i) > last_grant_r)) ? 1'b1 : hi_found_s;
            hi_idx_s   = (req_valid[i] && (OWN_W'(i) > last_grant_r)) ? OWN_W'(i) : hi_idx_s;
            lo_found_s = req_valid[i] ? 1'b1 : lo_found_s;
            lo_idx_s   = req_valid[i] ? OWN_W'(i) : lo_idx_s;
        end
        win_idx_s = hi_found_s ? hi_idx_s : lo_idx_s;
    end

    // Winner one-hot and multiplexing of the winner's request fields
    always_comb begin
        grant_oh_s  = '0;
        win_write_s = 1'b0;
        win_addr_s  = '0;
        win_wdata_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_oh_s[i] = lo_found_s && (OWN_W'(i) == win_idx_s);
            win_write_s   = (OWN_W'(i) == win_idx_s) ? req_write[i] : win_write_s;
            win_addr_s    = (OWN_W'(i) == win_idx_s) ? req_addr[i*ADDR_W +: ADDR_W] : win_addr_s;
            win_wdata_s   = (OWN_W'(i) == win_idx_s) ? req_wdata[i*DATA_W +: DATA_W] : win_wdata_s;
        end
    end

    // Address decode of the winning request into offset, instance and error
    always_comb begin
        reg_off_s   = win_addr_s[REG_W-1:0];
        dut_field_s = win_addr_s[ADDR_W-1:REG_W];
        dec_err_s   = (int'(reg_off_s) >= NUM_REGS) || (int'(dut_field_s) >= NUM_DUTS);
        dut_oh_s    = '0;
        for (int j = 0; j < NUM_DUTS; j++) begin
            dut_oh_s[j] = (int'(dut_field_s) == j);
        end
    end

    // Owner one-hot plus ack/read-data of the selected instance only; acks
    // from other instances never reach the FSM
    always_comb begin
        owner_oh_s  = '0;
        ack_sel_s   = 1'b0;
        rdata_sel_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_oh_s[i] = (OWN_W'(i) == owner_r);
        end
        for (int j = 0; j < NUM_DUTS; j++) begin
            ack_sel_s   = (DSEL_W'(j) == dut_r) ? bus_ack[j] : ack_sel_s;
            rdata_sel_s = (DSEL_W'(j) == dut_r) ? bus_rdata[j*DATA_W +: DATA_W] : rdata_sel_s;
        end
        timeout_hit_s = (cnt_r == CNT_W'(TIMEOUT - 1));
    end

    // Next-state logic; an ack beats a simultaneous timeout
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (lo_found_s) begin
                    state_next_s = dec_err_s ? ST_RESP : ST_ACCESS;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (ack_sel_s || timeout_hit_s) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_ACCESS;
                end
            end
            ST_RESP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Transaction capture, bus drive, timeout counter and response registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_r <= OWN_W'(NUM_REQ - 1);
            owner_r      <= '0;
            write_r      <= 1'b0;
            dut_r        <= '0;
            cnt_r        <= '0;
            bus_sel_r    <= '0;
            bus_write_r  <= 1'b0;
            bus_addr_r   <= '0;
            bus_wdata_r  <= '0;
            rsp_valid_r  <= '0;
            rsp_rdata_r  <= '0;
            rsp_err_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (lo_found_s) begin
                        owner_r      <= win_idx_s;
                        last_grant_r <= win_idx_s;
                        write_r      <= win_write_s;
                        dut_r        <= DSEL_W'(dut_field_s);
                        cnt_r        <= '0;
                        if (dec_err_s) begin
                            // Skip the bus entirely and answer next cycle
                            rsp_valid_r <= grant_oh_s;
                            rsp_err_r   <= 1'b1;
                            rsp_rdata_r <= '0;
                        end else begin
                            bus_sel_r   <= dut_oh_s;
                            bus_write_r <= win_write_s;
                            bus_addr_r  <= reg_off_s;
                            bus_wdata_r <= win_wdata_s;
                        end
                    end else begin
                        cnt_r <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (ack_sel_s || timeout_hit_s) begin
                        bus_sel_r   <= '0;
                        bus_write_r <= 1'b0;
                        bus_addr_r  <= '0;
                        bus_wdata_r <= '0;
                        rsp_valid_r <= owner_oh_s;
                        rsp_err_r   <= ~ack_sel_s;
                        rsp_rdata_r <= (ack_sel_s && !write_r) ? rdata_sel_s : '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    rsp_valid_r <= '0;
                    rsp_err_r   <= 1'b0;
                    rsp_rdata_r <= '0;
                    cnt_r       <= '0;
                end
                default: begin
                    bus_sel_r   <= '0;
                    rsp_valid_r <= '0;
                    cnt_r       <= '0;
                end
            endcase
        end
    end

    // Accept strobe is combinational and forced low while reset is held
    assign req_ready = (reset_n && (state_r == ST_IDLE)) ? grant_oh_s : '0;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign bus_sel   = bus_sel_r;
    assign bus_write = bus_write_r;
    assign bus_addr  = bus_addr_r;
    assign bus_wdata = bus_wdata_r;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for reg_access_arbiter (3 requesters, 2 instances, 10 regs, timeout 16).
// A transaction-level model (winner search by modular rotation, transaction age
// since handshake) predicts every output on every falling edge; directed
// sequences pin the model with literal expectations; random traffic follows.
// -----------------------------------------------------------------------------
module tb_reg_access_arbiter;

    localparam int NR = 3;
    localparam int ND = 2;
    localparam int NREGS = 10;
    localparam int DW = 32;
    localparam int RW = 4;
    localparam int AW = 8;
    localparam int TO = 16;

    logic              clk;
    logic              reset_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_write;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [ND-1:0]     bus_sel;
    logic              bus_write;
    logic [RW-1:0]     bus_addr;
    logic [DW-1:0]     bus_wdata;
    logic [ND*DW-1:0]  bus_rdata;
    logic [ND-1:0]     bus_ack;

    int total = 0;
    int bad = 0;

    // transaction-level model state
    bit          m_busy = 1'b0;
    int          m_last = NR - 1;
    int          m_owner, m_dut, m_reg, m_age, m_rsp_age;
    bit          m_wr, m_err;
    logic [DW-1:0] m_wdata, m_data;
    int          n_rsp = 0;

    reg_access_arbiter #(
        .NUM_REQ(NR), .NUM_DUTS(ND), .NUM_REGS(NREGS), .DATA_W(DW),
        .ADDR_W(AW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bus_sel(bus_sel), .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle model prediction and comparison, then model advance
    always @(negedge clk) begin : model_cmp
        logic [NR-1:0] e_ready, e_rvalid;
        logic [ND-1:0] e_sel;
        logic          e_wr, e_err;
        logic [RW-1:0] e_addr;
        logic [DW-1:0] e_wd, e_rd;
        logic [AW-1:0] a;
        int win, c;
        e_ready = '0; e_rvalid = '0; e_sel = '0; e_wr = 1'b0; e_err = 1'b0;
        e_addr = '0; e_wd = '0; e_rd = '0; win = -1;
        if (!reset_n) begin
            m_busy = 1'b0;
            m_last = NR - 1;
        end else if (!m_busy) begin
            for (int k = 1; k <= NR; k++) begin
                c = (m_last + k) % NR;
                if (win < 0 && ((req_valid >> c) & 3'b001) != 3'b000) win = c;
            end
            if (win >= 0) e_ready = 3'b001 << win;
        end else if (m_rsp_age != 0 && m_age == m_rsp_age) begin
            e_rvalid = 3'b001 << m_owner;
            e_err = m_err;
            e_rd = m_data;
        end else begin
            e_sel = 2'b01 << m_dut;
            e_wr = m_wr;
            e_addr = RW'(m_reg);
            e_wd = m_wdata;
        end

        chk("req_ready", 64'(req_ready), 64'(e_ready));
        chk("bus_sel", 64'(bus_sel), 64'(e_sel));
        chk("bus_write", 64'(bus_write), 64'(e_wr));
        chk("bus_addr", 64'(bus_addr), 64'(e_addr));
        chk("bus_wdata", 64'(bus_wdata), 64'(e_wd));
        chk("rsp_valid", 64'(rsp_valid), 64'(e_rvalid));
        chk("rsp_err", 64'(rsp_err), 64'(e_err));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rd));

        if (reset_n) begin
            if (!m_busy) begin
                if (win >= 0) begin
                    a = AW'(req_addr >> (win * AW));
                    m_busy = 1'b1;
                    m_owner = win;
                    m_last = win;
                    m_age = 1;
                    m_wr = (((req_write >> win) & 3'b001) != 3'b000);
                    m_wdata = DW'(req_wdata >> (win * DW));
                    m_reg = int'(a[3:0]);
                    m_dut = int'(a[7:4]);
                    if (m_reg >= NREGS || m_dut >= ND) begin
                        m_rsp_age = 1; m_err = 1'b1; m_data = '0;
                    end else begin
                        m_rsp_age = 0;
                    end
                end
            end else if (m_rsp_age != 0 && m_age == m_rsp_age) begin
                m_busy = 1'b0;
                n_rsp++;
            end else begin
                if (((bus_ack >> m_dut) & 2'b01) != 2'b00) begin
                    m_rsp_age = m_age + 1; m_err = 1'b0;
                    m_data = m_wr ? '0 : DW'(bus_rdata >> (m_dut * DW));
                end else if (m_age == TO) begin
                    m_rsp_age = m_age + 1; m_err = 1'b1; m_data = '0;
                end
                m_age++;
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input bit v, input bit w, input logic [7:0] a, input logic [31:0] d);
        req_valid[i] = v;
        req_write[i] = w;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic run_random(input int cycles, input int ack_div);
        logic [NR-1:0] hs;
        logic [3:0] rg, dx;
        for (int c = 0; c < cycles; c++) begin
            mid();
            hs = req_ready & req_valid;
            nxt();
            for (int i = 0; i < NR; i++) begin
                if (hs[i] || !req_valid[i]) begin
                    if ($urandom_range(0, 1) == 0) begin
                        rg = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
                        dx = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(2, 15)) : 4'($urandom_range(0, 1));
                        set_req(i, 1'b1, 1'($urandom_range(0, 1)), {dx, rg}, $urandom());
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            for (int j = 0; j < ND; j++) begin
                bus_ack[j] = ($urandom_range(0, ack_div - 1) == 0);
                bus_rdata[j*DW +: DW] = $urandom();
            end
        end
    endtask

    initial begin : main
        int n;
        bit done;
        reset_n = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        bus_ack = '0; bus_rdata = '0;
        #1 reset_n = 1'b0;
        mid();
        chk("rst_bus_sel", 64'(bus_sel), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        repeat (2) nxt();
        reset_n = 1'b1;

        // single write, ack in second access cycle
        set_req(0, 1'b1, 1'b1, 8'h03, 32'hDEADBEEF);
        mid(); chk("t1_ready", 64'(req_ready), 64'h1);
        nxt(); req_valid = '0;
        mid(); chk("t1_sel", 64'(bus_sel), 64'h1); chk("t1_addr", 64'(bus_addr), 64'h3);
        chk("t1_wdata", 64'(bus_wdata), 64'hDEADBEEF); chk("t1_write", 64'(bus_write), 64'h1);
        nxt(); bus_ack = 2'b01;
        mid(); chk("t1_sel_hold", 64'(bus_sel), 64'h1); chk("t1_wdata_hold", 64'(bus_wdata), 64'hDEADBEEF);
        nxt(); bus_ack = 2'b00;
        mid(); chk("t1_rsp", 64'(rsp_valid), 64'h1); chk("t1_err", 64'(rsp_err), 64'h0);
        chk("t1_rdata", 64'(rsp_rdata), 64'h0); chk("t1_sel_drop", 64'(bus_sel), 64'h0);
        nxt();
        mid(); chk("t1_rsp_once", 64'(rsp_valid), 64'h0);

        // read with zero-wait ack
        nxt(); set_req(1, 1'b1, 1'b0, 8'h05, 32'h0); bus_rdata[31:0] = 32'h12345678;
        mid(); chk("t2_ready", 64'(req_ready), 64'h2);
        nxt(); req_valid = '0; bus_ack = 2'b01;
        mid(); chk("t2_addr", 64'(bus_addr), 64'h5); chk("t2_write", 64'(bus_write), 64'h0);
        nxt(); bus_ack = 2'b00;
        mid(); chk("t2_rsp", 64'(rsp_valid), 64'h2); chk("t2_rdata", 64'(rsp_rdata), 64'h12345678);
        chk("t2_err", 64'(rsp_err), 64'h0);

        // contention after fresh reset: grants 0,1,2,0,1,2
        nxt(); reset_n = 1'b0;
        nxt(); nxt(); reset_n = 1'b1;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, 8'h01, 32'h0);
        bus_rdata[31:0] = 32'hCAFE0001; bus_ack = 2'b11;
        for (int k = 0; k < 6; k++) begin
            mid(); chk("t3_grant", 64'(req_ready), 64'(3'b001 << (k % 3)));
            nxt();
            mid(); chk("t3_sel", 64'(bus_sel), 64'h1);
            nxt();
            mid(); chk("t3_rsp_owner", 64'(rsp_valid), 64'(3'b001 << (k % 3)));
            chk("t3_rdata", 64'(rsp_rdata), 64'hCAFE0001);
            nxt();
        end
        req_valid = '0;

        // decode errors: reg_off 12, then dut_idx 2; stray acks ignored
        set_req(2, 1'b1, 1'b0, 8'h0C, 32'h0);
        mid(); chk("t4a_ready", 64'(req_ready), 64'h4);
        nxt(); req_valid = '0;
        mid(); chk("t4a_nosel", 64'(bus_sel), 64'h0); chk("t4a_rsp", 64'(rsp_valid), 64'h4);
        chk("t4a_err", 64'(rsp_err), 64'h1); chk("t4a_rdata", 64'(rsp_rdata), 64'h0);
        nxt(); set_req(0, 1'b1, 1'b1, 8'h21, 32'h11112222);
        mid(); chk("t4b_ready", 64'(req_ready), 64'h1);
        nxt(); req_valid = '0;
        mid(); chk("t4b_nosel", 64'(bus_sel), 64'h0); chk("t4b_rsp", 64'(rsp_valid), 64'h1);
        chk("t4b_err", 64'(rsp_err), 64'h1);
        nxt(); bus_ack = 2'b00;

        // timeout on instance 1, then a normal request
        set_req(1, 1'b1, 1'b1, 8'h12, 32'h0BADF00D);
        mid(); chk("t5_ready", 64'(req_ready), 64'h2);
        nxt(); req_valid = '0;
        n = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            mid();
            if (bus_sel == 2'b10) begin
                n++;
            end else if (rsp_valid != 3'b000) begin
                done = 1'b1;
                chk("t5_rsp", 64'(rsp_valid), 64'h2);
                chk("t5_err", 64'(rsp_err), 64'h1);
            end
            nxt();
        end
        chk("t5_resp_seen", 64'(done), 64'h1);
        chk("t5_sel_cycles", 64'(n), 64'd16);
        set_req(0, 1'b1, 1'b0, 8'h07, 32'h0); bus_rdata[31:0] = 32'h55AA55AA;
        mid(); chk("t5_next_ready", 64'(req_ready), 64'h1);
        nxt(); req_valid = '0; bus_ack = 2'b01;
        mid();
        nxt(); bus_ack = 2'b00;
        mid(); chk("t5_next_rsp", 64'(rsp_valid), 64'h1); chk("t5_next_rdata", 64'(rsp_rdata), 64'h55AA55AA);
        chk("t5_next_err", 64'(rsp_err), 64'h0);

        // reset during third access cycle
        nxt(); set_req(0, 1'b1, 1'b0, 8'h04, 32'h0);
        mid(); chk("t6_ready", 64'(req_ready), 64'h1);
        nxt(); set_req(1, 1'b1, 1'b0, 8'h02, 32'h0); set_req(2, 1'b1, 1'b0, 8'h03, 32'h0);
        mid();
        nxt();
        mid();
        nxt();
        chk("t6_sel_before", 64'(bus_sel), 64'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_sel_async", 64'(bus_sel), 64'h0);
        chk("t6_ready_async", 64'(req_ready), 64'h0);
        chk("t6_rsp_async", 64'(rsp_valid), 64'h0);
        nxt(); nxt(); reset_n = 1'b1;
        mid(); chk("t6_first_grant", 64'(req_ready), 64'h1);
        nxt(); req_valid = '0; bus_ack = 2'b01;
        mid();
        nxt(); bus_ack = 2'b00;
        mid(); chk("t6_rsp", 64'(rsp_valid), 64'h1);
        nxt();

        // randomized traffic: frequent acks, then sparse acks to hit timeouts
        run_random(3000, 3);
        run_random(1500, 40);
        chk("rand_responses", 64'(n_rsp > 200), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
